// File: rtl/multi_pulse_width_detector_pkg.sv
// Shared types and default sizing for the multi-channel pulse-width detector.
package multi_pulse_width_detector_pkg;

    typedef enum logic [1:0] {
        SYNC     = 2'd0,
        IDLE     = 2'd1,
        IN_PULSE = 2'd2
    } state_e;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/multi_pulse_width_detector_channel.sv
// One detector channel: sync/idle/in-pulse FSM, saturating width counter and
// the registered width of the last completed pulse.
module pulse_width_channel
    import multi_pulse_width_detector_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             polarity_i,
    input  logic [CNT_W-1:0] min_len_i,
    input  logic [CNT_W-1:0] max_len_i,
    output logic             lead_edge_o,
    output logic             detected_o,
    output logic             rejected_o,
    output logic [CNT_W-1:0] last_len_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_len_q;
    logic             pol_q;

    logic             act;
    logic             pol_chg;
    logic [CNT_W-1:0] eff_min;
    logic             in_win;
    logic             trail;

    assign act     = a_i ~^ polarity_i;
    assign pol_chg = polarity_i != pol_q;
    assign eff_min = (min_len_i == '0) ? ONE : min_len_i;
    // A saturated count is never accepted, even if max_len covers it.
    assign in_win  = (cnt_q >= eff_min) && (cnt_q <= max_len_i) && (cnt_q != CNT_MAX);
    assign trail   = (state_q == IN_PULSE) && !act && !pol_chg && !rst;

    assign lead_edge_o = (state_q == IDLE) && act && !pol_chg && !rst;
    assign detected_o  = trail && in_win;
    assign rejected_o  = trail && !in_win;
    assign last_len_o  = last_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SYNC;
            cnt_q      <= '0;
            last_len_q <= '0;
            pol_q      <= polarity_i;
        end else begin
            pol_q <= polarity_i;
            if (pol_chg) begin
                state_q <= SYNC;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    SYNC: begin
                        if (!act) state_q <= IDLE;
                    end
                    IDLE: begin
                        if (act) begin
                            state_q <= IN_PULSE;
                            cnt_q   <= ONE;
                        end
                    end
                    IN_PULSE: begin
                        if (act) begin
                            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + ONE;
                        end else begin
                            last_len_q <= cnt_q;
                            state_q    <= IDLE;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_pulse_width_detector.sv
// N_CH-channel pulse-width window detector with optional sticky status,
// enabled by defining MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN.
module multi_pulse_width_detector
    import multi_pulse_width_detector_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       polarity,
    input  logic [CNT_W-1:0]      min_len,
    input  logic [CNT_W-1:0]      max_len,
    output logic [N_CH-1:0]       lead_edge,
    output logic [N_CH-1:0]       detected,
    output logic [N_CH-1:0]       rejected,
    output logic [N_CH*CNT_W-1:0] last_len,
    input  logic [N_CH-1:0]       status_clr,
    output logic [N_CH-1:0]       status
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_width_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .a_i        (a[i]),
            .polarity_i (polarity[i]),
            .min_len_i  (min_len),
            .max_len_i  (max_len),
            .lead_edge_o(lead_edge[i]),
            .detected_o (detected[i]),
            .rejected_o (rejected[i]),
            .last_len_o (last_len[i*CNT_W +: CNT_W])
        );
    end

`ifdef MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN
    logic [N_CH-1:0] status_q;
    logic [N_CH-1:0] status_d;

    // A new detection outranks a clear arriving in the same cycle.
    always_comb begin
        status_d = (status_q & ~status_clr) | detected;
    end

    always_ff @(posedge clk) begin
        if (rst) status_q <= '0;
        else     status_q <= status_d;
    end

    assign status = status_q;
`else
    logic unused_status_clr;
    assign unused_status_clr = ^status_clr;
    assign status = '0;
`endif

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Self-checking bench: vector table, directed corner sequences and random
// stimulus against a behavioural pulse-run model.
module tb_multi_pulse_width_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a;
    logic [3:0]  polarity;
    logic [3:0]  min_len;
    logic [3:0]  max_len;
    logic [3:0]  lead_edge;
    logic [3:0]  detected;
    logic [3:0]  rejected;
    logic [15:0] last_len;
    logic [3:0]  status_clr;
    logic [3:0]  status;

    always #5 clk = ~clk;

    multi_pulse_width_detector #(.N_CH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .polarity  (polarity),
        .min_len   (min_len),
        .max_len   (max_len),
        .lead_edge (lead_edge),
        .detected  (detected),
        .rejected  (rejected),
        .last_len  (last_len),
        .status_clr(status_clr),
        .status    (status)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: run length of the current valid pulse, and whether the
    // previous sample was a qualifying inactive one.
    int         run  [4];
    bit         elig [4];
    logic [3:0] m_last [4];
    logic [3:0] m_pol;
    logic [3:0] m_status;

    logic [3:0]  obs_lead, obs_det, obs_rej, obs_status;
    logic [15:0] obs_last;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] av, input logic [3:0] pv,
                        input logic [3:0] mn, input logic [3:0] mx, input logic [3:0] cl);
        logic [3:0] e_lead, e_det, e_rej;
        logic [3:0] nl [4];
        int emin, w;
        bit act;
        rst = r; a = av; polarity = pv; min_len = mn; max_len = mx; status_clr = cl;
        @(negedge clk);
        obs_lead = lead_edge; obs_det = detected; obs_rej = rejected;
        obs_last = last_len;  obs_status = status;
        e_lead = '0; e_det = '0; e_rej = '0;
        emin = (mn == 4'd0) ? 1 : int'(mn);
        for (int c = 0; c < 4; c++) begin
            nl[c] = m_last[c];
            act = (av[c] == pv[c]);
            if (r || (pv[c] != m_pol[c])) begin
                run[c] = 0; elig[c] = 0;
                if (r) nl[c] = 4'd0;
            end else if (act) begin
                if (run[c] > 0) run[c]++;
                else if (elig[c]) begin e_lead[c] = 1'b1; run[c] = 1; end
                elig[c] = 0;
            end else begin
                if (run[c] > 0) begin
                    w = (run[c] > 15) ? 15 : run[c];
                    if (w >= emin && w <= int'(mx) && w < 15) e_det[c] = 1'b1;
                    else e_rej[c] = 1'b1;
                    nl[c] = 4'(w);
                    run[c] = 0;
                end
                elig[c] = 1;
            end
        end
        chk("model_lead", {12'd0, obs_lead}, {12'd0, e_lead});
        chk("model_det",  {12'd0, obs_det},  {12'd0, e_det});
        chk("model_rej",  {12'd0, obs_rej},  {12'd0, e_rej});
        chk("model_last", obs_last, {m_last[3], m_last[2], m_last[1], m_last[0]});
        chk("model_status", {12'd0, obs_status}, {12'd0, m_status});
        for (int c = 0; c < 4; c++) m_last[c] = nl[c];
`ifdef MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN
        m_status = r ? 4'd0 : ((m_status & ~cl) | e_det);
`else
        m_status = 4'd0;
`endif
        m_pol = pv;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       rst;
        logic       a0;
        logic [3:0] mn;
        logic [3:0] mx;
        logic       lead;
        logic       det;
        logic       rej;
        logic [3:0] last0;
    } vec_t;

    vec_t tbl [25];

    initial begin
        int d0, d1;
        int tp;
        logic [3:0] ra, rp, rmn, rmx;

        tbl[0]  = '{1'b1, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b1, 4'd1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'd1, 4'd4, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[8]  = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0, 1'b1, 4'd1};
        tbl[10] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[11] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[12] = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[13] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[14] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[15] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[16] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd2};
        tbl[17] = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[18] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 4'd4};
        tbl[19] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4};
        tbl[20] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4};
        tbl[21] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4};
        tbl[22] = '{1'b0, 1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4};
        tbl[23] = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4};
        tbl[24] = '{1'b0, 1'b0, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd5};

        for (int c = 0; c < 4; c++) begin run[c] = 0; elig[c] = 0; m_last[c] = 4'd0; end
        m_pol = 4'hF; m_status = 4'd0;
        rst = 1'b1; a = 4'h1; polarity = 4'hF; min_len = 4'd1; max_len = 4'd4; status_clr = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with input already active, then window classification.
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].rst, {3'b000, tbl[i].a0}, 4'hF, tbl[i].mn, tbl[i].mx, 4'h0);
            chk($sformatf("tbl%0d_lead", i), {12'd0, obs_lead}, {15'd0, tbl[i].lead});
            chk($sformatf("tbl%0d_det", i),  {12'd0, obs_det},  {15'd0, tbl[i].det});
            chk($sformatf("tbl%0d_rej", i),  {12'd0, obs_rej},  {15'd0, tbl[i].rej});
            chk($sformatf("tbl%0d_last", i), obs_last, {12'd0, tbl[i].last0});
        end

        // Saturating 20-cycle pulse with max_len at full scale.
        for (int i = 0; i < 20; i++) step(1'b0, 4'h1, 4'hF, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        chk("sat_rej", {12'd0, obs_rej}, 16'h0001);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        chk("sat_last", obs_last, 16'h000F);

        // Low polarity pulse, then polarity toggle mid-pulse.
        step(1'b1, 4'hF, 4'h0, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'hF, 4'h0, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'hE, 4'h0, 4'd1, 4'd15, 4'h0);
        chk("low_lead", {12'd0, obs_lead}, 16'h0001);
        step(1'b0, 4'hE, 4'h0, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'hF, 4'h0, 4'd1, 4'd15, 4'h0);
        chk("low_det", {12'd0, obs_det}, 16'h0001);
        step(1'b0, 4'hF, 4'h0, 4'd1, 4'd15, 4'h0);
        chk("low_last", obs_last, 16'h0002);
        step(1'b0, 4'hE, 4'h0, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'hE, 4'h0, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'hE, 4'h1, 4'd1, 4'd15, 4'h0);
        chk("tog_quiet0", {12'd0, obs_det | obs_rej}, 16'h0000);
        step(1'b0, 4'hE, 4'h1, 4'd1, 4'd15, 4'h0);
        chk("tog_quiet1", {12'd0, obs_det | obs_rej}, 16'h0000);
        step(1'b0, 4'hF, 4'h1, 4'd1, 4'd15, 4'h0);
        chk("tog_resync_lead", {12'd0, obs_lead}, 16'h0001);
        chk("tog_last_kept", obs_last, 16'h0002);

        // Back-to-back pulses on ch0 only.
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        d0 = 0; d1 = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, {3'b000, ~i[0]}, 4'hF, 4'd1, 4'd15, 4'h0);
            d0 += int'(obs_det[0]);
            d1 += int'(obs_det[1]) + int'(obs_rej[1]) + int'(obs_lead[1]);
        end
        chk("b2b_ch0_det", 16'(d0), 16'd2);
        chk("b2b_ch1_quiet", 16'(d1), 16'd0);

        // Sticky status on ch2: set, set-vs-clear, clear.
        step(1'b0, 4'h4, 4'hF, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
`ifdef MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN
        chk("sticky_set", {12'd0, obs_status}, 16'h0004);
`else
        chk("status_tied", {12'd0, obs_status}, 16'h0000);
`endif
        step(1'b0, 4'h4, 4'hF, 4'd1, 4'd15, 4'h0);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h4);
        chk("sticky_det2", {12'd0, obs_det}, 16'h0004);
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h4);
`ifdef MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN
        chk("sticky_set_wins", {12'd0, obs_status}, 16'h0004);
`endif
        step(1'b0, 4'h0, 4'hF, 4'd1, 4'd15, 4'h0);
        chk("sticky_cleared", {12'd0, obs_status}, 16'h0000);

        // Random traffic against the model.
        ra = 4'h0; rp = 4'hF; rmn = 4'd1; rmx = 4'd8; tp = 4;
        for (int n = 0; n < 3000; n++) begin
            if (n % 256 == 0) tp = $urandom_range(2, 20);
            if (n % 64 == 0) begin rmn = 4'($urandom_range(0, 15)); rmx = 4'($urandom_range(0, 15)); end
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(1, tp) == 1) ra[c] = ~ra[c];
                if ($urandom_range(0, 99) == 0) rp[c] = ~rp[c];
            end
            step(($urandom_range(0, 299) == 0), ra, rp, rmn, rmx, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_width_detector.md
Name: multi_pulse_width_detector

Overview:
- Per-channel pulse detector for N_CH independent single-bit inputs.
- Generalises the fixed one-cycle (010) detector: each channel accepts pulses whose width falls in a programmable window [min_len, max_len] cycles.
- Polarity is per channel: high pulse (0..1..0) or low pulse (1..0..1).
- Also reports leading/trailing edges and the measured width of the last completed pulse.
- Sits behind input synchronisers, feeding interrupt/status logic.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 4, width-counter bits; widths saturate at 2**CNT_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- a  input  N_CH  sampled channel inputs.
- polarity  input  N_CH  1 = detect high pulse, 0 = detect low pulse.
- min_len  input  CNT_W  minimum accepted width, shared by all channels.
- max_len  input  CNT_W  maximum accepted width, shared by all channels.
- lead_edge  output  N_CH  combinational; current cycle is the first active cycle.
- detected  output  N_CH  combinational; pulse just ended with width in window.
- rejected  output  N_CH  combinational; pulse just ended with width outside window.
- last_len  output  N_CH*CNT_W  registered width of last completed pulse; channel i at [i*CNT_W +: CNT_W].
- status_clr  input  N_CH  clears sticky status (see Optional Feature).
- status  output  N_CH  sticky detected flags (see Optional Feature).

Behaviour:
- Reset (rst=1): all channels go to SYNC; counters, last_len and status become 0.
- Outputs during and after reset: lead_edge, detected and rejected are 0 while in SYNC.
- Active level per channel: act = a ~^ polarity.
- Per-channel FSM has three states: SYNC, IDLE, IN_PULSE.
- SYNC:
  - Waits for act=0, then moves to IDLE the next cycle.
  - Prevents a false pulse when the input is already active out of reset.
- IDLE:
  - act=1 → lead_edge=1 this cycle, cnt<=1, next state IN_PULSE.
- IN_PULSE, act=1:
  - cnt<=cnt+1, saturating at 2**CNT_W-1.
- IN_PULSE, act=0 (trailing edge):
  - Same cycle: detected=1 if eff_min<=cnt<=max_len and cnt not saturated; otherwise rejected=1.
  - Next cycle: last_len<=cnt and state=IDLE.
- Latency: the 1-cycle pulse in cycle k gives lead_edge in cycle k and detected in cycle k+1. This matches the 010 timing.
- eff_min = max(min_len, 1).
- min_len > max_len: every pulse is rejected.
- A saturated count is always rejected, even when max_len = 2**CNT_W-1.
- Back-to-back pulses: trailing-edge cycle in IDLE-bound state, act=1 on the following cycle starts a new pulse normally. Minimum one inactive cycle is required between pulses.
- Polarity change: the channel registers polarity. Any change returns the channel to SYNC next cycle; no detected/rejected is produced for the interrupted pulse.
- Reset mid-pulse: no detected/rejected is produced; last_len is 0.
- min_len/max_len are sampled only at the trailing-edge cycle.

Optional Feature:
- Macro: MULTI_PULSE_WIDTH_DETECTOR_STICKY_STATUS_EN.
- Defined:
  - status[i] is set the cycle after detected[i]=1.
  - Cleared the cycle after status_clr[i]=1.
  - Simultaneous set and clear → set wins.
  - Reset → 0.
- Undefined: status is tied to 0 and status_clr is ignored. Ports remain present.

Decomposition:
- Package multi_pulse_width_detector_pkg:
  - state enum (SYNC, IDLE, IN_PULSE);
  - default-parameter localparams.
- Sub-module pulse_width_channel: one channel FSM, counter and last_len register.
- Top: generate loop over N_CH, plus the sticky status logic.

Test Plan:
- rst held with a=1, polarity=1; release → no lead_edge until a=0 seen. Then a=0,1,0 → lead_edge in the cycle a rises, detected in the cycle after, last_len=1.
- min_len=2, max_len=4, high polarity: pulses of width 1, 2, 4, 5 → rejected, detected, detected, rejected; last_len=1, 2, 4, 5.
- CNT_W=4, max_len=15: 20-cycle pulse → counter saturates at 15, rejected=1, last_len=15.
- polarity=0, a=1,0,0,1 → detected with last_len=2. Toggle polarity mid-pulse → no detected/rejected, channel re-syncs.
- Back-to-back high pulses 1,0,1,0 on channel 0 with channel 1 idle → two detected pulses on ch0 only, no cross-talk.
- With macro defined: detected on ch2 → status[2]=1. Assert status_clr[2] in the same cycle as a new detected → status stays 1. Clear alone → 0 next cycle.
